// File: rtl/mmio_initiator.sv
// mmio_initiator: queued valid/ready requests issued one at a time onto a single-cycle MMIO bus with a cs timeout
module mmio_initiator #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [7:0]  req_address,
  input  logic [31:0] req_write_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_read_data,
  output logic        rsp_error,
  output logic        busy,
  output logic        cs,
  output logic        we,
  output logic [7:0]  address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  input  logic        ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t        state_q;
  logic [40:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [CW-1:0] tmo_q;
  logic          cs_q, we_q, rsp_valid_q, rsp_error_q;
  logic [7:0]    addr_q;
  logic [31:0]   wdata_q, rdata_q;
  logic          full, empty, push, pop, tmo_hit;
  assign full      = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign empty     = cnt_q == '0;
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = state_q == IDLE && !empty;
  assign tmo_hit   = TIMEOUT_CYCLES != 0 && tmo_q == CW'(TIMEOUT_CYCLES - 1);
  assign busy      = state_q != IDLE || !empty;
  assign cs            = cs_q;
  assign we            = we_q;
  assign address       = addr_q;
  assign write_data    = wdata_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_read_data = rdata_q;
  assign rsp_error     = rsp_error_q;
  // occupancy: a simultaneous push and pop leaves the count unchanged
  always_comb begin
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // queue storage needs no reset; the pointers alone define its contents
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {req_we, req_address, req_write_data};
  end
  // queue pointers and count; reset flushes all queued requests
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
  // transaction sequencer: pop head, drive bus until ready or timeout, then hold the response
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tmo_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          {we_q, addr_q, wdata_q} <= mem_q[rd_q];
          cs_q    <= 1'b1;
          tmo_q   <= '0;
          state_q <= ACCESS;
        end
        ACCESS: if (ready || tmo_hit) begin
          rdata_q     <= ready && !we_q ? read_data : '0;
          rsp_error_q <= !ready;
          rsp_valid_q <= 1'b1;
          cs_q        <= 1'b0;
          we_q        <= 1'b0;
          addr_q      <= '0;
          wdata_q     <= '0;
          state_q     <= RESP;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_initiator.sv
// tb_mmio_initiator: directed vectors, corner sequences and randomized traffic against a response model
module tb_mmio_initiator;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_address;
  logic [31:0] req_write_data;
  logic        rsp_valid, rsp_ready, rsp_error, busy;
  logic [31:0] rsp_read_data;
  logic        cs, we, ready;
  logic [7:0]  address;
  logic [31:0] write_data, read_data;

  always #5 clk = ~clk;

  mmio_initiator #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_address(req_address), .req_write_data(req_write_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_read_data(rsp_read_data), .rsp_error(rsp_error), .busy(busy),
    .cs(cs), .we(we), .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready)
  );

  // responder: ready after a chosen number of cs cycles; data tagged with the cs cycle index
  logic        lat_mode = 1'b0;
  int          lat = 0;
  int          lat_eff;
  logic [31:0] rdv = '0;
  logic [7:0]  cs_cnt = '0;

  function automatic int lat_of(input logic [7:0] a);
    return a[4:0] > 5'd17 ? 255 : int'(a[4:0]);
  endfunction

  assign lat_eff   = lat_mode ? lat_of(address) : lat;
  assign ready     = cs && (int'(cs_cnt) >= lat_eff);
  assign read_data = (lat_mode ? {address, ~address, address, 8'h00} : rdv) ^ {24'h0, cs_cnt};

  always @(posedge clk) cs_cnt <= cs ? cs_cnt + 8'd1 : 8'd0;

  // log the address of every new cs pulse
  logic [7:0] alog[$];
  logic       cs_d = 1'b0;
  always @(negedge clk) begin
    if (cs && !cs_d) alog.push_back(address);
    cs_d = cs;
  end

  int pass_n = 0, total_n = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // expected {error, read_data} for a request under the address-driven responder
  function automatic logic [32:0] model(input logic w, input logic [7:0] a);
    int l = lat_of(a);
    if (l > 15) return {1'b1, 32'h0};
    if (w) return 33'h0;
    return {1'b0, {a, ~a, a, 8'h00} ^ 32'(l)};
  endfunction

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rdv;
    logic [31:0] exp_d;
    logic        exp_e;
    int          exp_cs;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int first, ncs, rspi;
    logic bad;
    lat_mode = 1'b0; lat = v.lat; rdv = v.rdv; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.w; req_address = v.a; req_write_data = v.wd;
    chk("vec_req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    first = -1; ncs = 0; rspi = -1; bad = 1'b0;
    for (int i = 0; i < 64 && rspi < 0; i++) begin
      if (cs) begin
        if (first < 0) first = i;
        ncs++;
        if ({we, address, write_data} !== {v.w, v.a, v.wd}) bad = 1'b1;
      end
      if (rsp_valid) rspi = i;
      else @(negedge clk);
    end
    chk("vec_rsp_seen", rspi >= 0, 1);
    chk("vec_cs_start", first, 1);
    chk("vec_cs_cycles", ncs, v.exp_cs);
    chk("vec_bus_fields", bad, 0);
    chk("vec_rsp_after_cs", rspi, first + ncs);
    chk("vec_read_data", rsp_read_data, v.exp_d);
    chk("vec_error", rsp_error, v.exp_e);
  endtask

  vec_t        tbl[8];
  logic [32:0] expq[$];
  logic [32:0] e;
  int          n0;
  logic        seen;

  initial begin
    tbl = '{
      '{1'b1, 8'h0a, 32'h0000_1234,   0, 32'hFFFF_FFFF, 32'h0,          1'b0,  1},
      '{1'b0, 8'h0b, 32'h0,           0, 32'hDEAD_BEEF, 32'hDEAD_BEEF,  1'b0,  1},
      '{1'b0, 8'h20, 32'h55,          2, 32'h1357_2468, 32'h1357_246A,  1'b0,  3},
      '{1'b1, 8'h30, 32'hCAFE_F00D,   2, 32'h0,         32'h0,          1'b0,  3},
      '{1'b0, 8'h40, 32'h0,         255, 32'h1111_1111, 32'h0,          1'b1, 16},
      '{1'b0, 8'h41, 32'h0,          15, 32'hA5A5_0000, 32'hA5A5_000F,  1'b0, 16},
      '{1'b1, 8'h43, 32'h77,         16, 32'h0,         32'h0,          1'b1, 16},
      '{1'b0, 8'h42, 32'h0,           0, 32'h0BAD_F00D, 32'h0BAD_F00D,  1'b0,  1}
    };
    req_valid = 1'b0; req_we = 1'b0; req_address = '0; req_write_data = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_bus", {cs, we, address, write_data}, 0);
    chk("reset_rsp", {rsp_valid, rsp_error, rsp_read_data, busy, req_ready}, 1);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) run_vec(tbl[i]);

    @(negedge clk);
    lat_mode = 1'b0; lat = 0; rsp_ready = 1'b0; n0 = alog.size();
    for (int k = 1; k <= 5; k++) begin
      req_valid = 1'b1; req_we = 1'b0; req_address = 8'(k); req_write_data = 32'(k);
      chk("bp_accept", req_ready, 1);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bp_full", req_ready, 0);
    repeat (5) @(negedge clk);
    chk("bp_one_pulse", alog.size() - n0, 1);
    rsp_ready = 1'b1;
    for (int c = 0; c < 200 && busy; c++) @(negedge clk);
    chk("bp_drained", busy, 0);
    chk("bp_pulses", alog.size() - n0, 5);
    for (int j = 0; j < 5 && n0 + j < alog.size(); j++) chk("bp_order", alog[n0 + j], j + 1);

    lat_mode = 1'b0; lat = 255; rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_address = 8'h60 + 8'(k);
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_pre_cs", cs, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid", {cs, busy, req_ready}, 3'b001);
    reset_n = 1'b1; lat = 0; seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid || cs) seen = 1'b1;
    end
    chk("rst_no_rsp", seen, 0);

    lat_mode = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      req_valid = $urandom_range(0, 1) == 1; req_we = 1'($urandom);
      req_address = 8'($urandom); req_write_data = $urandom;
      rsp_ready = $urandom_range(0, 3) != 0;
      if (rsp_valid && rsp_ready) begin
        if (expq.size() == 0) chk("rnd_spurious", 1, 0);
        else begin e = expq.pop_front(); chk("rnd_rsp", {rsp_error, rsp_read_data}, e); end
      end
      if (req_valid && req_ready) expq.push_back(model(req_we, req_address));
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int c = 0; c < 3000 && (busy || expq.size() != 0); c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (expq.size() == 0) chk("rnd_spurious", 1, 0);
        else begin e = expq.pop_front(); chk("rnd_rsp", {rsp_error, rsp_read_data}, e); end
      end
    end
    chk("rnd_drained", {busy, expq.size() == 0}, 2'b01);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
